// File: rtl/common_pkg.sv
// common_pkg: shared data-bus request/response types used by the memory stage and its responders
package common_pkg;
   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4} msize_t;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;
   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;
endpackage

// File: rtl/dbus_responder_pkg.sv
// dbus_responder_pkg: FSM state encoding and latency bound for dbus_responder
package dbus_responder_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int LATENCY_MAX = 15;
endpackage

// File: rtl/dbus_sram.sv
// dbus_sram: unreset word RAM, combinational read at idx, byte-enabled (be) synchronous write when we
module dbus_sram #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [2**DEPTH_LOG2];
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
   assign rdata = mem[idx];
endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: data-bus slave (req in, resp out, stall freezes latency, busy in flight, txn_cnt completions) backed by dbus_sram
module dbus_responder
   import common_pkg::*;
   import dbus_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  dbus_req_t   req,
   input  logic        stall,
   output dbus_resp_t  resp,
   output logic        busy,
   output logic [31:0] txn_cnt
);
   state_t                state, state_nx;
   logic [3:0]            cnt;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [3:0]            strobe_q;
   logic [31:0]           data_q, rdata;
   logic                  unused_ok;
   assign unused_ok = ^{req.addr, req.size};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? (req.valid ? ((LATENCY == 1) ? RESP : WAIT) : IDLE) :
                 (state == WAIT) ? ((!stall && cnt == 4'd1) ? RESP : WAIT) : IDLE;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt      <= '0;
         idx_q    <= '0;
         strobe_q <= '0;
         data_q   <= '0;
         txn_cnt  <= '0;
      end else begin
         if (state == IDLE && req.valid) begin
            cnt      <= 4'(LATENCY - 1);
            idx_q    <= req.addr[DEPTH_LOG2+1:2];
            strobe_q <= req.strobe;
            data_q   <= req.data;
         end
         if (state == WAIT && !stall) cnt <= cnt - 4'd1;
         if (state == RESP) txn_cnt <= txn_cnt + 32'd1;
      end
   always_comb begin
      resp.addr_ok = state == RESP;
      resp.data_ok = state == RESP;
      resp.data    = (state == RESP) ? rdata : '0;
      busy         = state != IDLE;
   end
   dbus_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
      .clk   (clk),
      .we    (state == RESP && |strobe_q),
      .be    (strobe_q),
      .idx   (idx_q),
      .wdata (data_q),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed and randomized checks of dbus_responder against a word-array reference model
module tb_dbus_responder;
   import common_pkg::*;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   dbus_req_t   req, req1;
   logic        stall, stall1;
   dbus_resp_t  resp, resp1;
   logic        busy, busy1;
   logic [31:0] txn_cnt, txn_cnt1;
   int          checks = 0;
   int          errors = 0;
   int          txn_exp = 0;
   int          txn1_exp = 0;
   logic [31:0] mem_m [int];
   logic [31:0] a1 [3];
   logic [31:0] d1 [3];

   always #5 clk = ~clk;

   dbus_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
      .clk(clk), .resetn(resetn), .req(req), .stall(stall),
      .resp(resp), .busy(busy), .txn_cnt(txn_cnt)
   );
   dbus_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .clk(clk), .resetn(resetn), .req(req1), .stall(stall1),
      .resp(resp1), .busy(busy1), .txn_cnt(txn_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'd1024);
   endfunction

   // One transaction on the LATENCY=2 instance; stall is held for s cycles right after acceptance
   task automatic txn(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                      input int s, input bit scramble);
      int          ix;
      int          ex;
      bit          known;
      logic [31:0] old;
      ix    = widx(a);
      known = mem_m.exists(ix);
      old   = known ? mem_m[ix] : 32'h0;
      ex    = 2 + s;
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      req   = '{valid: 1'b1, addr: a, size: MSIZE4, strobe: st, data: d};
      stall = 1'b0;
      for (int k = 1; k <= ex; k++) begin
         @(negedge clk);
         chk("busy", {31'b0, busy}, 32'd1);
         chk("data_ok", {31'b0, resp.data_ok}, {31'b0, k == ex});
         if (k == ex) begin
            chk("addr_ok", {31'b0, resp.addr_ok}, 32'd1);
            if (known) chk("rdata", resp.data, old);
         end else
            chk("data_zero", resp.data, 32'd0);
         stall = k <= s;
         if (scramble)
            req = '{valid: 1'b0, addr: $urandom, size: MSIZE1, strobe: 4'($urandom), data: $urandom};
      end
      req.valid = 1'b0;
      stall     = 1'b0;
      if (st == 4'hF) mem_m[ix] = d;
      else if (known)
         for (int i = 0; i < 4; i++)
            if (st[i]) mem_m[ix][8*i +: 8] = d[8*i +: 8];
      txn_exp++;
      @(negedge clk);
      chk("busy_after", {31'b0, busy}, 32'd0);
      chk("single_pulse", {31'b0, resp.data_ok}, 32'd0);
      chk("txn_cnt", txn_cnt, 32'(txn_exp));
   endtask

   // Three back-to-back requests on the LATENCY=1 instance with valid held high throughout
   task automatic burst1(input logic [3:0] st);
      @(negedge clk);
      req1 = '{valid: 1'b1, addr: a1[0], size: MSIZE4, strobe: st, data: d1[0]};
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("l1_ok", {31'b0, resp1.data_ok}, 32'd1);
         if (st == 4'h0) chk("l1_data", resp1.data, d1[j]);
         if (j < 2) begin
            req1.addr = a1[j+1];
            req1.data = d1[j+1];
         end else
            req1.valid = 1'b0;
         @(negedge clk);
         chk("l1_gap", {31'b0, resp1.data_ok}, 32'd0);
         chk("l1_gap_busy", {31'b0, busy1}, 32'd0);
      end
      txn1_exp += 3;
      chk("l1_txn_cnt", txn_cnt1, 32'(txn1_exp));
   endtask

   initial begin
      req    = '0;
      req1   = '0;
      stall  = 1'b0;
      stall1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_data_ok", {31'b0, resp.data_ok}, 32'd0);
      chk("rst_addr_ok", {31'b0, resp.addr_ok}, 32'd0);
      chk("rst_data", resp.data, 32'd0);
      chk("rst_txn", txn_cnt, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      txn(32'h100, 4'hF, 32'hDEADBEEF, 0, 1'b0);
      txn(32'h100, 4'h0, 32'h0, 0, 1'b0);
      chk("full_rw_txn2", txn_cnt, 32'd2);
      txn(32'h200, 4'hF, 32'h11223344, 0, 1'b0);
      txn(32'h200, 4'b0100, 32'h00AA0000, 0, 1'b0);
      txn(32'h200, 4'h0, 32'h0, 0, 1'b0);
      txn(32'h202, 4'h0, 32'h0, 0, 1'b1);
      chk("merge_model", mem_m[widx(32'h200)], 32'h11AA3344);
      txn(32'h1004, 4'hF, 32'hCAFEF00D, 0, 1'b0);
      txn(32'h0004, 4'h0, 32'h0, 0, 1'b0);
      txn(32'h0004, 4'h0, 32'h0, 5, 1'b0);
      txn(32'h300, 4'hF, 32'h0, 0, 1'b0);
      @(negedge clk);
      req = '{valid: 1'b1, addr: 32'h300, size: MSIZE4, strobe: 4'hF, data: 32'h55555555};
      @(negedge clk);
      chk("mid_busy", {31'b0, busy}, 32'd1);
      req.valid = 1'b0;
      resetn    = 1'b0;
      #1;
      chk("mrst_data_ok", {31'b0, resp.data_ok}, 32'd0);
      chk("mrst_addr_ok", {31'b0, resp.addr_ok}, 32'd0);
      chk("mrst_data", resp.data, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_txn", txn_cnt, 32'd0);
      txn_exp  = 0;
      txn1_exp = 0;
      @(negedge clk);
      resetn = 1'b1;
      txn(32'h300, 4'h0, 32'h0, 0, 1'b0);
      chk("mrst_mem", mem_m[widx(32'h300)], 32'h0);
      for (int i = 0; i < 16; i++)
         txn((32'(i) << 2) | ($urandom & 32'hFFFF_F003), 4'hF, $urandom, 0, 1'b0);
      for (int n = 0; n < 30; n++)
         txn((32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_F003), 4'($urandom),
             $urandom, int'($urandom_range(0, 3)), 1'($urandom));
      for (int j = 0; j < 3; j++) begin
         a1[j] = 32'h400 + 32'(j * 4);
         d1[j] = $urandom;
      end
      burst1(4'hF);
      burst1(4'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
